inst_mem_loader: RTL and testbench

Instruction-memory responder for the CPU fetch port. It answers rom_ce/rom_addr with rom_inst from an internal word array. It also contains a byte-stream boot loader that fills the array before the CPU runs. It sits outside riscv_cpu in the SoC top and is the memory end of the rom_addr/rom_ce/rom_inst interface.

---
 rtl/inst_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Purpose : CPU instruction memory with a little-endian byte-stream boot loader that fills it.
// Latency : fetch is combinational; a loaded word is readable the cycle after its write edge.
// Backpr. : ld_ready is high only while loading (LOAD/FULL); bytes offered at other times are not taken.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   rom_ce/rom_addr     CPU fetch request (byte address, low two bits ignored)
//   rom_inst            fetched word, zero when gated off
//   ld_start            pulse that begins a new image load at word 0
//   ld_valid/ld_data/ld_last/ld_ready   byte stream handshake
//   busy/done/ovf/word_cnt              loader status
module inst_mem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce,
    input  logic [31:0]           rom_addr,
    output logic [31:0]           rom_inst,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic                  ovf_q, ovf_d;

    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem [DEPTH];

    logic                  loading;
    logic                  accept;
    logic [31:0]           byte_word;
    logic [31:0]           merged;
    logic                  fetch_ok;
    logic                  unused_addr_lsbs;

    // Status is decoded from the state register; gating with rst keeps the
    // handshake quiet during the reset cycle itself, before the state settles.
    assign loading  = (state_q == LOAD) || (state_q == FULL);
    assign ld_ready = rst && loading;
    assign busy     = rst && loading;
    assign done     = rst && (state_q == DONE);
    assign ovf      = ovf_q;
    assign word_cnt = word_cnt_q;

    assign accept = ld_valid && ld_ready;

    // Place the incoming byte in its little-endian lane.
    always_comb begin
        byte_word = 32'h0;
        case (byte_idx_q)
            2'd0: byte_word = {24'h0, ld_data};
            2'd1: byte_word = {16'h0, ld_data, 8'h0};
            2'd2: byte_word = {8'h0, ld_data, 16'h0};
            default: byte_word = {ld_data, 24'h0};
        endcase
    end

    assign merged = asm_q | byte_word;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_wdata  = 32'h0;
        case (state_q)
            IDLE, DONE: begin
                if (ld_start) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                    byte_idx_d = 2'd0;
                    asm_d      = 32'h0;
                    ovf_d      = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if ((byte_idx_q == 2'd3) || ld_last) begin
                        // Lanes above the last byte are still zero in merged,
                        // so a short final word is zero-padded for free.
                        mem_we     = 1'b1;
                        mem_wdata  = merged;
                        word_cnt_d = word_cnt_q + CNT_ONE;
                        byte_idx_d = 2'd0;
                        asm_d      = 32'h0;
                        if (ld_last) begin
                            state_d = DONE;
                        end else if (word_cnt_d == DEPTH_CNT) begin
                            state_d = FULL;
                        end
                    end else begin
                        asm_d      = merged;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            FULL: begin
                // Array is full: keep draining the stream so the source can
                // finish, but flag that bytes were dropped.
                if (accept) begin
                    ovf_d = 1'b1;
                    if (ld_last) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'h0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            ovf_q      <= ovf_d;
        end
    end

    // Array is deliberately not reset so a program survives a CPU reset.
    // mem_we can only fire through accept, which is already masked by rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_cnt_q[ADDR_WIDTH-1:0]] <= mem_wdata;
        end
    end

    // Fetches are served only while the loader is not writing, and only for
    // byte addresses inside the array; anything else reads as zero.
    assign fetch_ok = rst && rom_ce &&
                      ((state_q == IDLE) || (state_q == DONE)) &&
                      (rom_addr[31:ADDR_WIDTH+2] == '0);

    assign rom_inst = fetch_ok ? mem[rom_addr[ADDR_WIDTH+1:2]] : 32'h0;

    // Byte offset within the word is irrelevant for word fetches.
    assign unused_addr_lsbs = ^rom_addr[1:0];

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b0;
    logic        rom_ce   = 1'b0;
    logic [31:0] rom_addr = 32'h0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data  = 8'h0;
    logic        ld_last  = 1'b0;

    // DUT a: default depth (1024 words). DUT b: depth 4 for overflow.
    logic [31:0] a_rom_inst, b_rom_inst;
    logic        a_ld_ready, a_busy, a_done, a_ovf;
    logic        b_ld_ready, b_busy, b_done, b_ovf;
    logic [10:0] a_word_cnt;
    logic [2:0]  b_word_cnt;

    inst_mem_loader #(.ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(a_rom_inst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(a_ld_ready), .busy(a_busy), .done(a_done), .ovf(a_ovf), .word_cnt(a_word_cnt)
    );

    inst_mem_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(b_rom_inst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(b_ld_ready), .busy(b_busy), .done(b_done), .ovf(b_ovf), .word_cnt(b_word_cnt)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int busy_cycles = 0;

    always @(posedge clk) begin
        if (a_busy) busy_cycles <= busy_cycles + 1;
    end

    // Scoreboard: expected (word address, word) pushed as bytes are driven.
    int unsigned  exp_addr[$];
    logic [31:0]  exp_data[$];

    // Reference loader model.
    bit           mdl_active;
    bit           mdl_full;
    int unsigned  mdl_idx;
    int unsigned  mdl_wcnt;
    int unsigned  mdl_depth;
    logic [31:0]  mdl_asm;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        mdl_active = 1'b1;
        mdl_full   = 1'b0;
        mdl_idx    = 0;
        mdl_wcnt   = 0;
        mdl_asm    = 32'h0;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit last);
        if (mdl_active) begin
            if (!mdl_full) begin
                mdl_asm = mdl_asm | ({24'h0, d} << (8 * mdl_idx));
                if (mdl_idx == 3 || last) begin
                    exp_addr.push_back(mdl_wcnt);
                    exp_data.push_back(mdl_asm);
                    mdl_wcnt = mdl_wcnt + 1;
                    mdl_idx  = 0;
                    mdl_asm  = 32'h0;
                    if (mdl_wcnt == mdl_depth && !last) mdl_full = 1'b1;
                end else begin
                    mdl_idx = mdl_idx + 1;
                end
            end
            if (last) mdl_active = 1'b0;
        end
    endtask

    // Offer one byte (after 'gap' idle cycles) and hold it until accepted.
    task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
        int n;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        n = 0;
        while (!a_ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (!a_ld_ready) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL send_timeout: ld_ready=%b after %0d cycles, required 1", a_ld_ready, n);
        end else begin
            tick();
            model_byte(d, last);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Pop every expected word and fetch it, with a random byte offset.
    task automatic drain(input bit use_b);
        logic [31:0] got;
        int unsigned a;
        logic [31:0] e;
        while (exp_addr.size() > 0) begin
            a = exp_addr.pop_front();
            e = exp_data.pop_front();
            rom_ce   = 1'b1;
            rom_addr = (a << 2) | $urandom_range(0, 3);
            #1;
            got = use_b ? b_rom_inst : a_rom_inst;
            vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL sb_fetch[%0d]: got %h, required %h", a, got, e);
            end
        end
        rom_ce = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({a_ld_ready, a_busy, a_done, a_ovf} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_flags: got rdy/busy/done/ovf=%b, required 0000",
                     {a_ld_ready, a_busy, a_done, a_ovf});
        end
        vec_cnt++;
        if (a_word_cnt !== 11'd0) begin
            err_cnt++;
            $display("FAIL reset_word_cnt: got %0d, required 0", a_word_cnt);
        end
        rom_ce = 1'b0;
        rom_addr = 32'h0;
        #1;
        vec_cnt++;
        if (a_rom_inst !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_rom_inst: got %h, required 0", a_rom_inst);
        end
    endtask

    task automatic test_main_load();
        logic [7:0] img [8];
        img = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        mdl_depth = 1024;
        busy_cycles = 0;
        start_load();
        for (int i = 0; i < 8; i++) send_byte(img[i], i == 7, 0);
        vec_cnt++;
        if (busy_cycles !== 8) begin
            err_cnt++;
            $display("FAIL main_busy_cycles: got %0d, required 8", busy_cycles);
        end
        vec_cnt++;
        if ({a_busy, a_done} !== 2'b01) begin
            err_cnt++;
            $display("FAIL main_done: got busy/done=%b, required 01", {a_busy, a_done});
        end
        vec_cnt++;
        if (a_word_cnt !== 11'd2) begin
            err_cnt++;
            $display("FAIL main_word_cnt: got %0d, required 2", a_word_cnt);
        end
        rom_ce = 1'b1;
        rom_addr = 32'd0;
        #1;
        vec_cnt++;
        if (a_rom_inst !== 32'h00500013) begin
            err_cnt++;
            $display("FAIL main_fetch0: got %h, required 00500013", a_rom_inst);
        end
        rom_addr = 32'd6;
        #1;
        vec_cnt++;
        if (a_rom_inst !== 32'h00100093) begin
            err_cnt++;
            $display("FAIL main_fetch6: got %h, required 00100093", a_rom_inst);
        end
        drain(1'b0);
    endtask

    task automatic test_partial_word();
        mdl_depth = 1024;
        start_load();
        send_byte(8'hAA, 1'b0, 1);
        send_byte(8'hBB, 1'b1, 1);
        vec_cnt++;
        if (a_word_cnt !== 11'd1 || a_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL partial_status: got cnt=%0d done=%b, required cnt=1 done=1", a_word_cnt, a_done);
        end
        // Held-high valid in DONE must not be taken.
        ld_valid = 1'b1;
        ld_data  = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        vec_cnt++;
        if (a_ld_ready !== 1'b0 || a_word_cnt !== 11'd1) begin
            err_cnt++;
            $display("FAIL partial_no_accept: got rdy=%b cnt=%0d, required rdy=0 cnt=1", a_ld_ready, a_word_cnt);
        end
        ld_valid = 1'b0;
        rom_ce = 1'b1;
        rom_addr = 32'd0;
        #1;
        vec_cnt++;
        if (a_rom_inst !== 32'h0000BBAA) begin
            err_cnt++;
            $display("FAIL partial_fetch: got %h, required 0000BBAA", a_rom_inst);
        end
        drain(1'b0);
    endtask

    task automatic test_read_gating();
        mdl_depth = 1024;
        start_load();
        send_byte(8'h55, 1'b0, 0);
        rom_ce = 1'b1;
        rom_addr = 32'h0;
        #1;
        vec_cnt++;
        if (a_rom_inst !== 32'h0) begin
            err_cnt++;
            $display("FAIL gate_during_load: got %h, required 0", a_rom_inst);
        end
        send_byte(8'h66, 1'b1, 0);
        rom_ce = 1'b1;
        rom_addr = 32'h00001000;
        #1;
        vec_cnt++;
        if (a_rom_inst !== 32'h0) begin
            err_cnt++;
            $display("FAIL gate_out_of_range: got %h, required 0", a_rom_inst);
        end
        rom_addr = 32'h00000010;
        #1;
        vec_cnt++;
        if (b_rom_inst !== 32'h0) begin
            err_cnt++;
            $display("FAIL gate_out_of_range_small: got %h, required 0", b_rom_inst);
        end
        rom_ce = 1'b0;
        rom_addr = 32'h0;
        #1;
        vec_cnt++;
        if (a_rom_inst !== 32'h0) begin
            err_cnt++;
            $display("FAIL gate_ce_low: got %h, required 0", a_rom_inst);
        end
        drain(1'b0);
    endtask

    task automatic test_overflow();
        mdl_depth = 4;
        start_load();
        for (int i = 1; i <= 20; i++) begin
            send_byte(8'(i), i == 20, 0);
            if (i == 16) begin
                vec_cnt++;
                if (b_word_cnt !== 3'd4 || b_busy !== 1'b1 || b_ovf !== 1'b0 || b_ld_ready !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL ovf_full: got cnt=%0d busy=%b ovf=%b rdy=%b, required 4 1 0 1",
                             b_word_cnt, b_busy, b_ovf, b_ld_ready);
                end
            end
            if (i == 17) begin
                vec_cnt++;
                if (b_ovf !== 1'b1 || b_word_cnt !== 3'd4) begin
                    err_cnt++;
                    $display("FAIL ovf_set: got ovf=%b cnt=%0d, required ovf=1 cnt=4", b_ovf, b_word_cnt);
                end
            end
        end
        vec_cnt++;
        if (b_done !== 1'b1 || b_word_cnt !== 3'd4 || b_ovf !== 1'b1) begin
            err_cnt++;
            $display("FAIL ovf_done: got done=%b cnt=%0d ovf=%b, required 1 4 1", b_done, b_word_cnt, b_ovf);
        end
        vec_cnt++;
        if (a_word_cnt !== 11'd5 || a_ovf !== 1'b0) begin
            err_cnt++;
            $display("FAIL ovf_big_dut: got cnt=%0d ovf=%b, required 5 0", a_word_cnt, a_ovf);
        end
        rom_ce = 1'b1;
        rom_addr = 32'd12;
        #1;
        vec_cnt++;
        if (b_rom_inst !== 32'h100F0E0D) begin
            err_cnt++;
            $display("FAIL ovf_last_word: got %h, required 100F0E0D", b_rom_inst);
        end
        drain(1'b1);
        // A fresh load clears the overflow flag.
        mdl_depth = 1024;
        start_load();
        vec_cnt++;
        if (b_ovf !== 1'b0 || b_word_cnt !== 3'd0 || b_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL ovf_restart: got ovf=%b cnt=%0d busy=%b, required 0 0 1", b_ovf, b_word_cnt, b_busy);
        end
        send_byte(8'h77, 1'b1, 0);
        while (exp_addr.size() > 0) begin
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
        end
    endtask

    task automatic test_reset_mid_load();
        mdl_depth = 1024;
        start_load();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), 1'b0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mdl_active = 1'b0;
        #1;
        vec_cnt++;
        if ({a_ld_ready, a_busy, a_done, a_ovf} !== 4'b0000 || a_word_cnt !== 11'd0) begin
            err_cnt++;
            $display("FAIL mid_reset_state: got rdy/busy/done/ovf=%b cnt=%0d, required 0000 0",
                     {a_ld_ready, a_busy, a_done, a_ovf}, a_word_cnt);
        end
        drain(1'b0);
        start_load();
        vec_cnt++;
        if (a_busy !== 1'b1 || a_ovf !== 1'b0 || a_word_cnt !== 11'd0) begin
            err_cnt++;
            $display("FAIL mid_restart: got busy=%b ovf=%b cnt=%0d, required 1 0 0", a_busy, a_ovf, a_word_cnt);
        end
        for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), i == 3, 0);
        vec_cnt++;
        if (a_done !== 1'b1 || a_word_cnt !== 11'd1) begin
            err_cnt++;
            $display("FAIL mid_reload_done: got done=%b cnt=%0d, required 1 1", a_done, a_word_cnt);
        end
        drain(1'b0);
    endtask

    initial begin
        mdl_active = 1'b0;
        mdl_full   = 1'b0;
        mdl_idx    = 0;
        mdl_wcnt   = 0;
        mdl_depth  = 1024;
        mdl_asm    = 32'h0;
        test_reset();
        test_main_load();
        test_partial_word();
        test_read_gating();
        test_overflow();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
